// File: rtl/dma_pkg.sv
// Shared definitions for the strided surface/line DMA engines (reader and writer).
package dma_pkg;

  // AXI4 encodings used by the DMA masters
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Beat counts go up to 256, so they need one bit more than AWLEN
  localparam int BEAT_W = 9;

  // Write-side sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_WAIT_B,
    ST_DONE
  } dma_state_t;

  // Number of whole pixels between an aligned address and the next 4KB page
  function automatic logic [12:0] beats_to_4k(input logic [11:0] page_off,
                                              input int unsigned pix_shift);
    logic [12:0] bytes_left;
    bytes_left = 13'h1000 - {1'b0, page_off};
    return bytes_left >> pix_shift;
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Walks the ch_grp / h / w traversal of a strided surface and hands out one
// burst (address + beat count) at a time, never crossing a line or a 4KB page.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int DIM_W       = 16,
  parameter int MAX_BURST   = 16,
  parameter int PIXEL_BYTES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  advance,
  input  logic [AXI_ADDR_W-1:0] cfg_base,
  input  logic [AXI_ADDR_W-1:0] cfg_surf_strd,
  input  logic [AXI_ADDR_W-1:0] cfg_line_strd,
  input  logic [DIM_W-1:0]      cfg_win,
  input  logic [DIM_W-1:0]      cfg_hin,
  input  logic [DIM_W-1:0]      cfg_chgrp,
  output logic [AXI_ADDR_W-1:0] burst_addr,
  output logic [BEAT_W-1:0]     burst_beats,
  output logic                  last_burst
);

  localparam int PIX_SHIFT = $clog2(PIXEL_BYTES);
  localparam int CMP_W     = (DIM_W > 13) ? DIM_W : 13;

  logic [AXI_ADDR_W-1:0] surf_strd;
  logic [AXI_ADDR_W-1:0] line_strd;
  logic [DIM_W-1:0]      win;
  logic [DIM_W-1:0]      hin;
  logic [DIM_W-1:0]      chgrp;

  logic [DIM_W-1:0]      cg_cnt;
  logic [DIM_W-1:0]      h_cnt;
  logic [DIM_W-1:0]      w_cnt;
  logic [AXI_ADDR_W-1:0] surf_addr;
  logic [AXI_ADDR_W-1:0] line_addr;
  logic [AXI_ADDR_W-1:0] cur_addr;

  logic [CMP_W-1:0]      rem_pix;
  logic [CMP_W-1:0]      page_beats;
  logic [CMP_W-1:0]      max_beats;
  logic [CMP_W-1:0]      min_beats;
  logic [DIM_W:0]        w_next;
  logic [AXI_ADDR_W-1:0] step;
  logic                  line_end;
  logic                  grp_end;
  logic                  job_end;

  // Burst size is the smallest of: pixels left in the line, the burst cap, room left in the 4KB page
  always_comb begin
    rem_pix    = CMP_W'(win - w_cnt);
    page_beats = CMP_W'(beats_to_4k(cur_addr[11:0], PIX_SHIFT));
    max_beats  = CMP_W'(MAX_BURST);
    min_beats  = (rem_pix < max_beats) ? rem_pix : max_beats;
    if (page_beats < min_beats) begin
      min_beats = page_beats;
    end
    w_next   = {1'b0, w_cnt} + (DIM_W + 1)'(min_beats);
    step     = AXI_ADDR_W'(min_beats) << PIX_SHIFT;
    line_end = (w_next == {1'b0, win});
    grp_end  = line_end && (h_cnt == hin - DIM_W'(1));
    job_end  = grp_end && (cg_cnt == chgrp - DIM_W'(1));
  end

  assign burst_addr  = cur_addr;
  assign burst_beats = min_beats[BEAT_W-1:0];
  assign last_burst  = job_end;

  // Latch the job geometry on init, then step to the next burst each time one is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      surf_strd <= '0;
      line_strd <= '0;
      win       <= '0;
      hin       <= '0;
      chgrp     <= '0;
      cg_cnt    <= '0;
      h_cnt     <= '0;
      w_cnt     <= '0;
      surf_addr <= '0;
      line_addr <= '0;
      cur_addr  <= '0;
    end else if (init) begin
      surf_strd <= cfg_surf_strd;
      line_strd <= cfg_line_strd;
      win       <= cfg_win;
      hin       <= cfg_hin;
      chgrp     <= cfg_chgrp;
      cg_cnt    <= '0;
      h_cnt     <= '0;
      w_cnt     <= '0;
      surf_addr <= cfg_base;
      line_addr <= cfg_base;
      cur_addr  <= cfg_base;
    end else if (advance) begin
      if (!line_end) begin
        w_cnt    <= w_next[DIM_W-1:0];
        cur_addr <= cur_addr + step;
      end else begin
        w_cnt <= '0;
        if (!grp_end) begin
          h_cnt     <= h_cnt + DIM_W'(1);
          line_addr <= line_addr + line_strd;
          cur_addr  <= line_addr + line_strd;
        end else begin
          h_cnt     <= '0;
          cg_cnt    <= cg_cnt + DIM_W'(1);
          surf_addr <= surf_addr + surf_strd;
          line_addr <= surf_addr + surf_strd;
          cur_addr  <= surf_addr + surf_strd;
        end
      end
    end
  end

endmodule

// File: rtl/mvm_dat_out_wr_dma.sv
// Output write-back DMA: takes Tout-packed result pixels and writes them to DDR
// through an AXI4 write master using the strided surface/line layout.
module mvm_dat_out_wr_dma
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DAT_W       = 256,
  parameter int AXI_ID_W        = 4,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DIM_W           = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AXI_ADDR_W-1:0]    cfg_base,
  input  logic [AXI_ADDR_W-1:0]    cfg_surf_strd,
  input  logic [AXI_ADDR_W-1:0]    cfg_line_strd,
  input  logic [DIM_W-1:0]         cfg_win,
  input  logic [DIM_W-1:0]         cfg_hin,
  input  logic [DIM_W-1:0]         cfg_chgrp,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [AXI_DAT_W-1:0]     s_data,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [AXI_ADDR_W-1:0]    m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic [AXI_ID_W-1:0]      m_awid,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [AXI_DAT_W-1:0]     m_wdata,
  output logic [AXI_DAT_W/8-1:0]   m_wstrb,
  output logic                     m_wlast,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  input  logic [1:0]               m_bresp,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int         PIXEL_BYTES = AXI_DAT_W / 8;
  localparam int         OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [2:0] AW_SIZE     = 3'($clog2(PIXEL_BYTES));

  dma_state_t         state;
  logic [OUT_W-1:0]   outstanding;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  burst_len;
  logic               final_burst;
  logic               err_r;

  logic [AXI_ADDR_W-1:0] ag_addr;
  logic [BEAT_W-1:0]     ag_beats;
  logic                  ag_last;
  logic                  ag_init;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  beat_is_last;

  dma_addr_gen #(
    .AXI_ADDR_W  (AXI_ADDR_W),
    .DIM_W       (DIM_W),
    .MAX_BURST   (MAX_BURST),
    .PIXEL_BYTES (PIXEL_BYTES)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .init          (ag_init),
    .advance       (aw_hs),
    .cfg_base      (cfg_base),
    .cfg_surf_strd (cfg_surf_strd),
    .cfg_line_strd (cfg_line_strd),
    .cfg_win       (cfg_win),
    .cfg_hin       (cfg_hin),
    .cfg_chgrp     (cfg_chgrp),
    .burst_addr    (ag_addr),
    .burst_beats   (ag_beats),
    .last_burst    (ag_last)
  );

  // Handshake decode and state-driven AXI / stream outputs; W data is a pure passthrough
  always_comb begin
    ag_init      = (state == ST_IDLE) && start;
    beat_is_last = (beat_cnt == burst_len - BEAT_W'(1));

    m_awvalid = (state == ST_AW) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    m_awaddr  = ag_addr;
    m_awlen   = 8'(ag_beats - BEAT_W'(1));
    m_awsize  = AW_SIZE;
    m_awburst = AXI_BURST_INCR;
    m_awid    = '0;

    m_wvalid  = (state == ST_W) && s_valid;
    s_ready   = (state == ST_W) && m_wready;
    m_wdata   = s_data;
    m_wstrb   = '1;
    m_wlast   = (state == ST_W) && beat_is_last;

    m_bready  = (state != ST_IDLE);

    aw_hs = m_awvalid && m_awready;
    w_hs  = m_wvalid && m_wready;
    b_hs  = m_bvalid && m_bready;

    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    err  = err_r;
  end

  // Job sequencer: issue a burst address, stream its beats, repeat, then drain write responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      outstanding <= '0;
      beat_cnt    <= '0;
      burst_len   <= '0;
      final_burst <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (aw_hs && !b_hs) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (b_hs && !aw_hs) begin
        outstanding <= outstanding - OUT_W'(1);
      end

      if (b_hs && (m_bresp != AXI_RESP_OKAY)) begin
        err_r <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            err_r <= 1'b0;
            state <= ST_AW;
          end
        end
        ST_AW: begin
          if (aw_hs) begin
            burst_len   <= ag_beats;
            final_burst <= ag_last;
            beat_cnt    <= '0;
            state       <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            if (beat_is_last) begin
              state <= final_burst ? ST_WAIT_B : ST_AW;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_WAIT_B: begin
          if (outstanding == '0) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
